// File: rtl/mul_tree.sv
// Four-lane float32 multiplier tree: lane products, pair products and a
// full product, selected by mode, with a fixed three-cycle latency.
module mul_tree (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] mul_ins,
  input  logic         mul_stb,
  input  logic [1:0]   mode,
  output logic [127:0] outputs,
  output logic [3:0]   final_output_stbs
);

  function automatic logic [31:0] fmul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic              s;
    logic              az, bz, ai, bi, an, bn;
    logic [47:0]       prod;
    logic [22:0]       frac;
    logic              g, st, rnd;
    logic [23:0]       m;
    logic signed [9:0] e;
    logic [31:0]       res;
    s  = a[31] ^ b[31];
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    ai = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    an = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]})
      + $signed({2'b00, b[30:23]})
      - 10'sd127;
    if (prod[47]) begin
      frac = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
      e    = e + 10'sd1;
    end else begin
      frac = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    rnd = g & (st | frac[0]);
    m   = {1'b0, frac} + {23'd0, rnd};
    // carry out of the fraction means 1.111.. rounded up to 10.000..
    if (m[23]) e = e + 10'sd1;
    if (an | bn | (az & bi) | (ai & bz))
      res = 32'h7fc00000;
    else if (ai | bi)
      res = {s, 8'hff, 23'd0};
    else if (az | bz)
      res = {s, 31'd0};
    else if (e >= 10'sd255)
      res = {s, 8'hff, 23'd0};
    else if (e <= 10'sd0)
      res = {s, 31'd0};
    else
      res = {s, e[7:0], m[22:0]};
    return res;
  endfunction

  logic         va, vb, vc;
  logic [1:0]   ma, mb, mc;
  logic [127:0] pa, pb, pc;
  logic [63:0]  qb, qc;
  logic [31:0]  rc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      va <= 1'b0;
      ma <= 2'd0;
      pa <= '0;
    end else begin
      va <= mul_stb;
      ma <= mode;
      for (int k = 0; k < 4; k++)
        pa[32*k +: 32] <= fmul(mul_ins[64*k+32 +: 32],
                               mul_ins[64*k +: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vb <= 1'b0;
      mb <= 2'd0;
      pb <= '0;
      qb <= '0;
    end else begin
      vb <= va;
      mb <= ma;
      pb <= pa;
      qb <= {fmul(pa[64 +: 32], pa[96 +: 32]),
             fmul(pa[0 +: 32], pa[32 +: 32])};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc <= 1'b0;
      mc <= 2'd0;
      pc <= '0;
      qc <= '0;
      rc <= '0;
    end else begin
      vc <= vb;
      mc <= mb;
      pc <= pb;
      qc <= qb;
      rc <= fmul(qb[0 +: 32], qb[32 +: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outputs           <= '0;
      final_output_stbs <= 4'b0000;
    end else begin
      final_output_stbs <= 4'b0000;
      if (vc) begin
        unique case (mc)
          2'b00: begin
            outputs           <= pc;
            final_output_stbs <= 4'b1111;
          end
          2'b01: begin
            outputs[63:0]     <= qc;
            final_output_stbs <= 4'b0011;
          end
          2'b10: begin
            outputs[31:0]     <= qc[31:0];
            outputs[95:32]    <= pc[127:64];
            final_output_stbs <= 4'b0111;
          end
          default: begin
            outputs[31:0]     <= rc;
            final_output_stbs <= 4'b0001;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_tree.sv
// Self-checking bench for mul_tree: arithmetic float model plus
// directed literal vectors, streaming and mid-stream reset.
module tb_mul_tree;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] mul_ins = '0;
  logic         mul_stb = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [127:0] outputs;
  logic [3:0]   final_output_stbs;

  int checks = 0;
  int errors = 0;

  mul_tree dut (
    .clk               (clk),
    .rst               (rst),
    .mul_ins           (mul_ins),
    .mul_stb           (mul_stb),
    .mode              (mode),
    .outputs           (outputs),
    .final_output_stbs (final_output_stbs)
  );

  always #5 clk = ~clk;

  // Reference float multiply from plain integer arithmetic.
  function automatic logic [31:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    int     ea, eb, sh, ex;
    bit     s, za, zb, ia, ib, na, nb;
    longint p, q, rem, half;
    logic [31:0] e32;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (za && ib) || (ia && zb)) return 32'h7fc00000;
    if (ia || ib) return {s, 8'hff, 23'd0};
    if (za || zb) return {s, 31'd0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    sh = 0;
    while ((p >> sh) >= (64'sd1 << 24)) sh++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'sd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'sd1 << 24)) begin
      q = q >> 1;
      sh++;
    end
    ex = ea + eb - 150 + sh;
    if (ex >= 255) return {s, 8'hff, 23'd0};
    if (ex <= 0) return {s, 31'd0};
    e32 = ex;
    return {s, e32[7:0], q[22:0]};
  endfunction

  // Model: three-deep queue of sampled input sets.
  logic         pv [3];
  logic [1:0]   pm [3];
  logic [255:0] pi [3];
  logic [127:0] exp_out = '0;
  logic [3:0]   exp_stb = '0;

  initial for (int i = 0; i < 3; i++) begin
    pv[i] = 1'b0; pm[i] = 2'b00; pi[i] = '0;
  end

  always @(posedge clk or negedge rst) begin
    logic         lv;
    logic [1:0]   lm;
    logic [255:0] li;
    logic [31:0]  p [4];
    logic [31:0]  q0, q1, r;
    if (!rst) begin
      for (int i = 0; i < 3; i++) pv[i] = 1'b0;
      exp_out = '0;
      exp_stb = '0;
    end else begin
      lv = pv[2]; lm = pm[2]; li = pi[2];
      pv[2] = pv[1]; pm[2] = pm[1]; pi[2] = pi[1];
      pv[1] = pv[0]; pm[1] = pm[0]; pi[1] = pi[0];
      pv[0] = mul_stb; pm[0] = mode; pi[0] = mul_ins;
      exp_stb = 4'b0000;
      if (lv) begin
        for (int k = 0; k < 4; k++)
          p[k] = ref_mul(li[64*k+32 +: 32], li[64*k +: 32]);
        q0 = ref_mul(p[0], p[1]);
        q1 = ref_mul(p[2], p[3]);
        r  = ref_mul(q0, q1);
        case (lm)
          2'b00: begin
            exp_out = {p[3], p[2], p[1], p[0]};
            exp_stb = 4'b1111;
          end
          2'b01: begin
            exp_out[63:0] = {q1, q0};
            exp_stb = 4'b0011;
          end
          2'b10: begin
            exp_out[95:0] = {p[3], p[2], q0};
            exp_stb = 4'b0111;
          end
          default: begin
            exp_out[31:0] = r;
            exp_stb = 4'b0001;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (outputs !== exp_out || final_output_stbs !== exp_stb) begin
      errors++;
      $display("FAIL model t=%0t out=%h stb=%b expected out=%h stb=%b",
               $time, outputs, final_output_stbs, exp_out, exp_stb);
    end
  end

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  function automatic logic [255:0] pack(
    input logic [31:0] a0, b0, a1, b1, a2, b2, a3, b3
  );
    return {a3, b3, a2, b2, a1, b1, a0, b0};
  endfunction

  // Drive one set, then check the literal result 3 edges later.
  task automatic one_shot(input string name, input logic [255:0] ins,
                          input logic [1:0] md, input logic [127:0] want,
                          input logic [3:0] wstb);
    mul_ins = ins;
    mode    = md;
    mul_stb = 1'b1;
    @(negedge clk);
    mul_stb = 1'b0;
    repeat (3) @(negedge clk);
    chk({name, "_out"}, outputs, want);
    chk({name, "_stb"}, {124'd0, final_output_stbs}, {124'd0, wstb});
    @(negedge clk);
    chk({name, "_pulse"}, {124'd0, final_output_stbs}, 128'd0);
  endtask

  logic [255:0] base;

  initial begin
    base = pack(32'h3f800000, 32'h40000000, 32'h40400000, 32'h3f000000,
                32'h40000000, 32'h40000000, 32'hbf800000, 32'h40800000);
    repeat (3) @(negedge clk);
    chk("reset_out", outputs, 128'd0);
    chk("reset_stb", {124'd0, final_output_stbs}, 128'd0);
    rst = 1'b1;
    @(negedge clk);

    one_shot("m00", base, 2'b00,
             {32'hc0800000, 32'h40800000, 32'h3fc00000, 32'h40000000},
             4'b1111);
    one_shot("m01", base, 2'b01,
             {32'hc0800000, 32'h40800000, 32'hc1800000, 32'h40400000},
             4'b0011);
    one_shot("m10", base, 2'b10,
             {32'hc0800000, 32'hc0800000, 32'h40800000, 32'h40400000},
             4'b0111);
    one_shot("m11", base, 2'b11,
             {32'hc0800000, 32'hc0800000, 32'h40800000, 32'hc2400000},
             4'b0001);
    one_shot("special",
             pack(32'h00000000, 32'h7f800000, 32'h7f7fffff, 32'h40000000,
                  32'h00400000, 32'h40000000, 32'h3f800001, 32'h3f800001),
             2'b00,
             {32'h3f800002, 32'h00000000, 32'h7f800000, 32'h7fc00000},
             4'b1111);

    for (int i = 0; i < 16; i++) begin
      mul_ins = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
      mode    = (i % 2 == 1) ? 2'b11 : 2'b00;
      mul_stb = 1'b1;
      @(negedge clk);
    end
    mul_stb = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      mul_ins = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
      mode    = 2'(i % 4);
      mul_stb = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", outputs, 128'd0);
    chk("async_rst_stb", {124'd0, final_output_stbs}, 128'd0);
    @(negedge clk);
    mul_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    one_shot("post_rst", base, 2'b11,
             {96'd0, 32'hc2400000}, 4'b0001);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
